// File: rtl/fast_pkg.sv
// Shared definitions for the FAST front end: feeder state encoding, default
// frame geometry and the pixel/coordinate widths the patch builder and NMS use.
package fast_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_PAD,
        ST_DROP,
        ST_FLUSH
    } feeder_state_e;

    localparam int COL_NUM_DEF      = 640;
    localparam int ROW_NUM_DEF      = 480;
    localparam int PIXEL_WIDTH_DEF  = 8;
    localparam int FLUSH_CYCLES_DEF = 3 * COL_NUM_DEF + 16;

    localparam int COL_WIDTH_DEF    = $clog2(COL_NUM_DEF);
    localparam int ROW_WIDTH_DEF    = $clog2(ROW_NUM_DEF);

endpackage

// File: rtl/fast_pixel_feeder.sv
// FAST pipeline front end. Takes DMA pixels from AXI4-Stream and drives the
// line buffer with exactly COL_NUM x ROW_NUM registered enables per frame,
// padding short lines and dropping the tail of long ones, then issues
// FLUSH_CYCLES dummy enables to drain the patch/score pipeline and pulses
// frame_done. FLUSH_CYCLES must stay below 6*COL_NUM.
module fast_pixel_feeder
    import fast_pkg::*;
#(
    parameter int                     COL_NUM      = COL_NUM_DEF,
    parameter int                     ROW_NUM      = ROW_NUM_DEF,
    parameter int                     PIXEL_WIDTH  = PIXEL_WIDTH_DEF,
    parameter int                     FLUSH_CYCLES = FLUSH_CYCLES_DEF,
    parameter logic [PIXEL_WIDTH-1:0] PAD_VALUE    = '0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   stall,
    input  logic [PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tuser,
    input  logic                   s_axis_tlast,
    output logic [PIXEL_WIDTH-1:0] pix_data,
    output logic                   pix_ce,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   err_eol,
    output logic                   err_sof,
    input  logic                   err_clr
);

    localparam int COL_W   = $clog2(COL_NUM);
    localparam int ROW_W   = $clog2(ROW_NUM);
    localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COL_NUM - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROW_NUM - 1);
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);

    feeder_state_e          state_q, state_d;
    logic [COL_W-1:0]       col_q, col_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [FLUSH_W-1:0]     flush_cnt_q, flush_cnt_d;
    logic [PIXEL_WIDTH-1:0] pix_data_q, pix_data_d;
    logic                   pix_ce_q, pix_ce_d;
    logic                   done_arm_q, done_arm_d;
    logic                   frame_done_q;
    logic                   err_eol_q, err_eol_d;
    logic                   err_sof_q, err_sof_d;
    logic                   ready;
    logic                   beat;
    logic                   set_eol, set_sof;

    // Per-state ready. In IDLE a stalled start-of-frame beat is held off so
    // pixel (0,0) is never swallowed, while non-tuser beats keep draining.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
        ready = 1'b0;
        unique case (state_q)
            ST_IDLE:   ready = enable & ~(stall & s_axis_tuser);
            ST_STREAM: ready = ~stall;
            ST_DROP:   ready = 1'b1;
            default:   ready = 1'b0;
        endcase
    end

    // tready is forced low while reset is asserted, since IDLE would otherwise echo enable.
    assign s_axis_tready = rst_n & ready;
    assign beat          = s_axis_tvalid & ready;

    // Next-state logic: FSM transitions, col/row/flush counters and the pixel bus.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        flush_cnt_d = flush_cnt_q;
        pix_data_d  = pix_data_q;
        pix_ce_d    = 1'b0;
        done_arm_d  = 1'b0;
        set_eol     = 1'b0;
        set_sof     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (beat && s_axis_tuser) begin
                    pix_ce_d   = 1'b1;
                    pix_data_d = s_axis_tdata;
                    col_d      = col_q + 1'b1;
                    state_d    = ST_STREAM;
                end
            end

            ST_STREAM: begin
                if (beat) begin
                    pix_ce_d   = 1'b1;
                    pix_data_d = s_axis_tdata;
                    set_sof    = s_axis_tuser;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            // Final pixel of the frame: tlast is not checked here.
                            state_d = ST_FLUSH;
                        end else begin
                            row_d = row_q + 1'b1;
                            if (!s_axis_tlast) begin
                                set_eol = 1'b1;
                                state_d = ST_DROP;
                            end
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                        if (s_axis_tlast) begin
                            set_eol = 1'b1;
                            state_d = ST_PAD;
                        end
                    end
                end
            end

            ST_PAD: begin
                if (!stall) begin
                    pix_ce_d   = 1'b1;
                    pix_data_d = PAD_VALUE;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = ST_FLUSH;
                        end else begin
                            row_d   = row_q + 1'b1;
                            state_d = ST_STREAM;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            ST_DROP: begin
                // The row counter already points at the next line; the last
                // line never enters DROP because it goes straight to FLUSH.
                if (beat && s_axis_tlast) begin
                    state_d = ST_STREAM;
                end
            end

            ST_FLUSH: begin
                if (!stall) begin
                    pix_ce_d   = 1'b1;
                    pix_data_d = PAD_VALUE;
                    if (flush_cnt_q == FLUSH_LAST) begin
                        flush_cnt_d = '0;
                        row_d       = '0;
                        col_d       = '0;
                        done_arm_d  = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky error flags; a same-cycle clear beats a set.
    always_comb begin
        err_eol_d = err_clr ? 1'b0 : (err_eol_q | set_eol);
        err_sof_d = err_clr ? 1'b0 : (err_sof_q | set_sof);
    end

    // State, counters and the output register stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            flush_cnt_q  <= '0;
            pix_data_q   <= '0;
            pix_ce_q     <= 1'b0;
            done_arm_q   <= 1'b0;
            frame_done_q <= 1'b0;
            err_eol_q    <= 1'b0;
            err_sof_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the pre-edge values.
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            flush_cnt_q  <= flush_cnt_d;
            pix_data_q   <= pix_data_d;
            pix_ce_q     <= pix_ce_d;
            done_arm_q   <= done_arm_d;
            frame_done_q <= done_arm_q;
            err_eol_q    <= err_eol_d;
            err_sof_q    <= err_sof_d;
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_ce     = pix_ce_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign err_eol    = err_eol_q;
    assign err_sof    = err_sof_q;

endmodule
